// File: rtl/clic_int_pad_drv_if.sv
// Pad-driver bus bundle: groups every non-clock/reset signal of clic_int_pad_drv.
//   master : stimulus side (drives raw requests, config writes, acks, self-test start)
//   slave  : the pad driver (drives pad bus, pending status, self-test status)
// Ports (all IDW-wide fields follow the IDW parameter):
//   src_int_req[63:0]      raw peripheral interrupt requests
//   cfg_wr_en/idx/mode     one-cycle per-line mode write (0 level, 1 edge-latched)
//   clic_int_ack_vld/id    one-cycle CLIC acknowledge by line ID
//   tst_start              start the walking-one self-test
//   pad_clic_int_vld[63:0] request bus towards the CLIC pads
//   drv_pend_vec[63:0]     edge-latched pending bits
//   tst_busy / tst_done    self-test in progress / one-cycle completion pulse
interface clic_int_pad_drv_if #(
  parameter int unsigned IDW = 6
);
  logic [63:0]    src_int_req;
  logic           cfg_wr_en;
  logic [IDW-1:0] cfg_wr_idx;
  logic           cfg_wr_mode;
  logic           clic_int_ack_vld;
  logic [IDW-1:0] clic_int_ack_id;
  logic           tst_start;
  logic [63:0]    pad_clic_int_vld;
  logic [63:0]    drv_pend_vec;
  logic           tst_busy;
  logic           tst_done;

  modport master (
    output src_int_req, cfg_wr_en, cfg_wr_idx, cfg_wr_mode,
    output clic_int_ack_vld, clic_int_ack_id, tst_start,
    input  pad_clic_int_vld, drv_pend_vec, tst_busy, tst_done
  );

  modport slave (
    input  src_int_req, cfg_wr_en, cfg_wr_idx, cfg_wr_mode,
    input  clic_int_ack_vld, clic_int_ack_id, tst_start,
    output pad_clic_int_vld, drv_pend_vec, tst_busy, tst_done
  );
endinterface

// File: rtl/clic_int_pad_drv.sv
// CLIC pad-side interrupt driver.
// Converts raw peripheral events into per-line level or edge-latched requests on
// pad_clic_int_vld; edge-latched lines stay pending until acknowledged by ID.
// A walking-one self-test sequencer can take over the pad bus.
// Ports:
//   forever_cpuclk  clock, rising edge
//   cpurst_b        synchronous active-low reset
//   bus             clic_int_pad_drv_if.slave (requests, config, ack, self-test, pad bus)
// Optional build macro CLIC_PAD_DRV_SYNC_EN: adds a 2-flop synchronizer on src_int_req
// (latency becomes 3 cycles, edge detection on synchronized values).
module clic_int_pad_drv #(
  parameter int unsigned INT_NUM   = 64,
  parameter int unsigned IDW       = 6,
  parameter int unsigned TST_DWELL = 4
) (
  input logic                  forever_cpuclk,
  input logic                  cpurst_b,
  clic_int_pad_drv_if.slave    bus
);

  localparam logic [63:0] LineMask = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - INT_NUM);

  typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

  logic [63:0]    src_in, src_q, mode_q, mode_d, pend_q, pend_d;
  logic [63:0]    rise, ack_hot, wr_hot;
  state_e         state_q;
  logic [IDW-1:0] idx_q;
  logic [7:0]     dwell_q;
  logic           tst_busy_q, tst_done_q;

`ifdef CLIC_PAD_DRV_SYNC_EN
  logic [63:0] sync1_q, sync2_q;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.src_int_req;
      sync2_q <= sync1_q;
    end
  end

  assign src_in = sync2_q;
`else
  assign src_in = bus.src_int_req;
`endif

  assign rise = src_in & ~src_q;

  always_comb begin
    ack_hot = '0;
    if (bus.clic_int_ack_vld && (32'(bus.clic_int_ack_id) < INT_NUM)) begin
      ack_hot = 64'd1 << bus.clic_int_ack_id;
    end
    wr_hot = '0;
    if (bus.cfg_wr_en && (32'(bus.cfg_wr_idx) < INT_NUM)) begin
      wr_hot = 64'd1 << bus.cfg_wr_idx;
    end
    mode_d = (mode_q & ~wr_hot) | (wr_hot & {64{bus.cfg_wr_mode}});
    // Only lines already in edge mode can latch, and a line leaving edge mode drops its
    // pend on the same edge; a rising edge beats a coincident ack.
    pend_d = mode_d & mode_q & (rise | (pend_q & ~ack_hot));
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      src_q  <= '0;
      mode_q <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= src_in;
      mode_q <= mode_d;
      pend_q <= pend_d;
    end
  end

  // Self-test sequencer with registered status outputs.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      dwell_q    <= '0;
      tst_busy_q <= 1'b0;
      tst_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tst_done_q <= 1'b0;
          if (bus.tst_start) begin
            state_q    <= StWalk;
            idx_q      <= '0;
            dwell_q    <= '0;
            tst_busy_q <= 1'b1;
          end
        end
        StWalk: begin
          if (dwell_q == 8'(TST_DWELL - 1)) begin
            dwell_q <= '0;
            if (idx_q == IDW'(INT_NUM - 1)) begin
              idx_q      <= '0;
              state_q    <= StDone;
              tst_busy_q <= 1'b0;
              tst_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            dwell_q <= dwell_q + 8'd1;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          tst_done_q <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          tst_busy_q <= 1'b0;
          tst_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Walk overrides the pad; the src/pend path keeps running underneath.
  assign bus.pad_clic_int_vld = tst_busy_q ? ((64'd1 << idx_q) & LineMask)
                                           : (((mode_q & pend_q) | (~mode_q & src_q)) & LineMask);
  assign bus.drv_pend_vec     = pend_q & LineMask;
  assign bus.tst_busy         = tst_busy_q;
  assign bus.tst_done         = tst_done_q;

endmodule

// File: doc/clic_int_pad_drv.md
Name: clic_int_pad_drv

Overview:
- Drives the CLIC pad-side interrupt request bus `pad_clic_int_vld` on the SoC/testbench side of the CLIC.
- Converts raw peripheral interrupt events into per-line level or edge-latched requests. Edge-latched requests are held until the CLIC acknowledges them by ID.
- Contains a walking-one self-test sequencer that exercises every pad line in turn.

Parameters:
- INT_NUM, 64, number of driven interrupt lines (1..64); lines at or above INT_NUM are tied 0 on the pad.
- IDW, 6, width of interrupt index/ID fields; must satisfy 2^IDW >= INT_NUM.
- TST_DWELL, 4, cycles each line is held high during self-test walk (1..255).

Ports:
- forever_cpuclk  in  1  single clock; all flops rising-edge.
- cpurst_b  in  1  reset, synchronous, active-low.
- src_int_req  in  64  raw peripheral interrupt requests.
- cfg_wr_en  in  1  one-cycle strobe: write mode bit of line cfg_wr_idx.
- cfg_wr_idx  in  IDW  line index for config write.
- cfg_wr_mode  in  1  0 = level passthrough, 1 = edge-latched.
- clic_int_ack_vld  in  1  one-cycle CLIC acknowledge strobe.
- clic_int_ack_id  in  IDW  ID of acknowledged line.
- tst_start  in  1  start self-test walk.
- pad_clic_int_vld  out  64  interrupt request bus to CLIC pads.
- drv_pend_vec  out  64  edge-latched pending bits (status).
- tst_busy  out  1  high while walk in progress.
- tst_done  out  1  one-cycle pulse when walk completes.

Behaviour:
- Reset (cpurst_b == 0 at clock edge):
  - src_q, mode, pend, FSM state, walk index and dwell counter all clear.
  - All outputs 0.
  - Reset mid-walk returns to IDLE with no tst_done pulse.
- src_q <= src_int_req each cycle (registered sample).
- Config write:
  - mode[cfg_wr_idx] <= cfg_wr_mode, effective next cycle.
  - cfg_wr_idx >= INT_NUM ignored.
- Level line (mode = 0):
  - pad bit = src_q bit, so latency is 1 cycle from src_int_req.
  - pend bit held 0; acks to the line ignored.
- Edge line (mode = 1):
  - A rising edge (src_int_req = 1 while src_q = 0) sets pend next cycle.
  - pad bit = pend bit.
  - Ack with matching ID clears pend next cycle.
  - Simultaneous rising edge and ack on the same line: pend stays 1 (new event wins).
  - Ack to a line with pend = 0, or ack ID >= INT_NUM: no effect.
- Mode change 1 -> 0 clears pend for that line on the same edge. Mode change 0 -> 1 does not set pend even if src_q is high; only a later rising edge sets it.
- drv_pend_vec = pend (bits >= INT_NUM are 0).
- Self-test FSM, states IDLE, WALK, DONE:
  - IDLE: tst_start = 1 -> WALK, idx = 0, dwell = 0. tst_start ignored in WALK or DONE.
  - WALK: dwell increments each cycle. When dwell == TST_DWELL-1: dwell = 0 and idx++. When this happens with idx == INT_NUM-1 -> DONE.
  - DONE: tst_done = 1 for exactly one cycle, then IDLE.
  - tst_busy = 1 in WALK only.
  - During WALK, pad_clic_int_vld = one-hot(idx); the normal src/pend path is masked from the pad but keeps updating (edges latch, acks clear).
  - Entering WALK from tst_start at edge N: pad bit 0 is high for cycles N+1..N+TST_DWELL.
  - Total walk length is INT_NUM*TST_DWELL cycles.
- Width rules: idx is IDW bits and never exceeds INT_NUM-1; dwell counter is 8 bits.

Optional Feature:
- CLIC_PAD_DRV_SYNC_EN
- Defined:
  - src_int_req passes through a 2-flop synchronizer (reset 0) before src_q, for asynchronous peripheral sources.
  - Level and edge latency becomes 3 cycles.
  - Edge detection operates on synchronized values.
- Undefined: direct single-flop sample, 1-cycle latency as above.

Test Plan:
- Reset then idle: hold cpurst_b = 0 for 2 cycles with src_int_req = all-ones -> pad_clic_int_vld = 0, drv_pend_vec = 0, tst_busy = 0 throughout reset. 1 cycle after release, pad = 64'hFFFF_FFFF_FFFF_FFFF (all level mode).
- Level path: set src_int_req[5] = 1 at edge N -> pad[5] = 1 from N+1. Drop it at M -> pad[5] = 0 at M+1. Ack ID 5 has no effect.
- Edge latch/ack: mode[9] = 1. Pulse src_int_req[9] for 1 cycle -> pad[9] = 1 and stays 1 for 20 cycles. ack ID 9 -> pad[9] = 0 next cycle. Ack ID 9 again -> stays 0.
- Ack/edge collision: mode[3] = 1, pend[3] = 1. Drop src[3] for 1 cycle, then raise src[3] in the same cycle as ack ID 3 -> pend[3] remains 1. Ack ID 3 alone next -> pend[3] = 0.
- Self-test walk: INT_NUM = 64, TST_DWELL = 4, tst_start at N -> tst_busy = 1 during N+1..N+256. pad = 1 << k during cycles N+1+4k..N+4+4k. tst_done pulses at N+257. A second tst_start at N+10 is ignored.
- Reset mid-walk at idx = 20 -> next cycle tst_busy = 0, pad = 0, no tst_done. With CLIC_PAD_DRV_SYNC_EN defined, repeat the level test -> pad[5] rises at N+3.
